// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared constants and types for the front end of the pipeline.
//   ADDR_W / INSTR_W : address and instruction widths
//   PC_STEP          : sequential fetch increment in bytes
//   NOP_INSTR        : instruction shown in IF/ID when it holds no real instruction
//   fetch_state_t    : fetch-stage FSM states
//   next_seq_pc()    : modulo-2^ADDR_W sequential successor of an address
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 16'd2;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Plain ADDR_W-bit add: the carry out is dropped, so 0xFFFE wraps to 0x0000.
  function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg
// IF/ID pipeline register with load / hold / clear control.
//   clk, reset       : clock, asynchronous active-high reset (clears to NOP)
//   load             : capture instr_d / pc_d / pc_plus2_d and mark valid
//   clear            : squash to NOP and mark invalid (wins over load)
//   neither          : hold current contents
//   instr, pc, pc_plus2, valid : register contents
module if_id_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc_d,
  input  logic [ADDR_W-1:0]  pc_plus2_d,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus2,
  output logic               valid
);

  // Clear only forces the instruction to NOP and drops valid; the address
  // fields are don't-care while invalid, so they are simply left alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus2 <= '0;
      valid    <= 1'b0;
    end else if (clear) begin
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_d;
      pc       <= pc_d;
      pc_plus2 <= pc_plus2_d;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_id_fetch.sv
// if_id_fetch
// Instruction-fetch stage sitting right after the PC register. Runs the
// valid/ready handshake with instruction memory, fills the IF/ID register and
// tells the PC register when to hold.
//   clk, reset           : clock, asynchronous active-high reset
//   pc_in                : fetch address from the PC register
//   stall                : decode/hazard stall, IF/ID must hold
//   flush                : taken branch, squash IF/ID and any in-flight fetch
//   imem_ready/imem_rdata: memory response (data valid when ready)
//   imem_req/imem_addr   : memory request, address stable until ready
//   pc_plus2             : pc_in + PC_STEP for the next-PC mux
//   fetch_busy           : PC register must hold (its repeat input)
//   if_id_*              : IF/ID pipeline register contents
module if_id_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               stall,
  input  logic               flush,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  pc_plus2,
  output logic               fetch_busy,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  logic               ifid_load;
  logic               ifid_clear;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_d;
  logic [ADDR_W-1:0]  ifid_pc_plus2_d;

  assign pc_plus2 = next_seq_pc(pc_in);

  // Request, busy and IF/ID control decoded from the current state.
  // In FETCH the PC register is released as soon as the memory answers and
  // decode is not stalled, which gives back-to-back fetches with no bubble.
  // In DRAIN the squashed request is finished at its old address while the PC
  // register is free to take the branch target.
  always_comb begin
    imem_req        = 1'b1;
    imem_addr       = pc_in;
    fetch_busy      = 1'b0;
    ifid_load       = 1'b0;
    ifid_clear      = 1'b0;
    ifid_instr_d    = imem_rdata;
    ifid_pc_d       = pc_in;
    ifid_pc_plus2_d = pc_plus2;

    case (state)
      FETCH: begin
        fetch_busy = !imem_ready || stall;
        if (flush) begin
          ifid_clear = 1'b1;
        end else if (!stall) begin
          if (imem_ready) ifid_load  = 1'b1;
          else            ifid_clear = 1'b1;
        end
      end

      DRAIN: begin
        imem_addr  = addr_q;
        ifid_clear = !stall;
      end

      HOLD: begin
        imem_req        = 1'b0;
        fetch_busy      = 1'b1;
        ifid_instr_d    = skid_instr;
        ifid_pc_d       = skid_pc;
        ifid_pc_plus2_d = next_seq_pc(skid_pc);
        if (flush)       ifid_clear = 1'b1;
        else if (!stall) ifid_load  = 1'b1;
      end

      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // FSM with the skid buffer and the outstanding-request address. The skid
  // buffer catches an instruction that arrives while decode is stalled, since
  // the memory cannot be asked to hold its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      addr_q     <= '0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else begin
      case (state)
        FETCH: begin
          addr_q <= pc_in;
          if (imem_ready) begin
            if (!flush && stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc_in;
              state      <= HOLD;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          if (imem_ready) state <= FETCH;
        end

        HOLD: begin
          if (flush || !stall) state <= FETCH;
        end

        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .clear      (ifid_clear),
    .instr_d    (ifid_instr_d),
    .pc_d       (ifid_pc_d),
    .pc_plus2_d (ifid_pc_plus2_d),
    .instr      (if_id_instr),
    .pc         (if_id_pc),
    .pc_plus2   (if_id_pc_plus2),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_if_id_fetch.sv
// tb_if_id_fetch
// Directed bench for if_id_fetch. A behavioural model of the fetch stage is
// checked against the DUT on every negedge; directed steps also pin selected
// outputs to hand-computed constants.
module tb_if_id_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_in;
  logic        stall;
  logic        flush;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc_plus2;
  logic        fetch_busy;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  if_id_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .stall          (stall),
    .flush          (flush),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .pc_plus2       (pc_plus2),
    .fetch_busy     (fetch_busy),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the stage in terms of what is pending: an instruction parked
  // because decode was stalled, or a squashed request still owed by memory.
  logic [15:0] m_instr, m_pc, m_pc2;
  bit          m_valid;
  bit          m_parked;
  logic [15:0] m_park_instr, m_park_pc;
  bit          m_owed;
  logic [15:0] m_owed_addr;

  task automatic mdlReset();
    m_valid = 0; m_instr = 16'h0000; m_pc = 16'h0000; m_pc2 = 16'h0000;
    m_parked = 0; m_owed = 0; m_owed_addr = 16'h0000;
  endtask

  task automatic mdlSquash();
    m_valid = 0;
    m_instr = 16'h0000;
  endtask

  task automatic mdlDeliver(input logic [15:0] instr, input logic [15:0] pc);
    m_valid = 1;
    m_instr = instr;
    m_pc    = pc;
    m_pc2   = pc + 16'd2;
  endtask

  task automatic mdlStep();
    if (m_parked) begin
      if (flush) begin
        mdlSquash();
        m_parked = 0;
      end else if (!stall) begin
        mdlDeliver(m_park_instr, m_park_pc);
        m_parked = 0;
      end
    end else if (m_owed) begin
      if (!stall) mdlSquash();
      if (imem_ready) m_owed = 0;
    end else if (imem_ready) begin
      if (flush) mdlSquash();
      else if (stall) begin
        m_parked     = 1;
        m_park_instr = imem_rdata;
        m_park_pc    = pc_in;
      end else mdlDeliver(imem_rdata, pc_in);
    end else begin
      if (flush) begin
        mdlSquash();
        m_owed      = 1;
        m_owed_addr = pc_in;
      end else if (!stall) mdlSquash();
    end
  endtask

  // Compare on negedge, advance the model on posedge.
  initial begin
    logic [15:0] e_pc2;
    mdlReset();
    forever begin
      @(negedge clk);
      if (reset) mdlReset();
      e_pc2 = pc_in + 16'd2;
      checkOutput("pc_plus2", {16'h0, pc_plus2}, {16'h0, e_pc2});
      checkOutput("imem_req", {31'h0, imem_req}, {31'h0, !m_parked});
      if (!reset && !m_parked)
        checkOutput("imem_addr", {16'h0, imem_addr}, {16'h0, (m_owed ? m_owed_addr : pc_in)});
      if (!reset)
        checkOutput("fetch_busy", {31'h0, fetch_busy},
                    {31'h0, (m_parked ? 1'b1 : (m_owed ? 1'b0 : (!imem_ready || stall)))});
      checkOutput("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
      checkOutput("if_id_instr", {16'h0, if_id_instr}, {16'h0, m_instr});
      if (m_valid) begin
        checkOutput("if_id_pc", {16'h0, if_id_pc}, {16'h0, m_pc});
        checkOutput("if_id_pc_plus2", {16'h0, if_id_pc_plus2}, {16'h0, m_pc2});
      end
      @(posedge clk);
      if (reset) mdlReset();
      else       mdlStep();
    end
  end

  // Drive one cycle's inputs shortly after posedge and let them settle.
  task automatic applyStimulus(input logic [15:0] pc, input logic st, input logic fl,
                               input logic rdy, input logic [15:0] rdata);
    pc_in = pc; stall = st; flush = fl; imem_ready = rdy; imem_rdata = rdata;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [15:0] instr,
                           input logic [15:0] pc, input logic [15:0] pc2);
    checkOutput({tag, "_valid"}, {31'h0, if_id_valid}, 32'h1);
    checkOutput({tag, "_instr"}, {16'h0, if_id_instr}, {16'h0, instr});
    checkOutput({tag, "_pc"},    {16'h0, if_id_pc},    {16'h0, pc});
    checkOutput({tag, "_pc2"},   {16'h0, if_id_pc_plus2}, {16'h0, pc2});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] seq_pc [3];
    logic [15:0] seq_in [3];
    seq_pc = '{16'h0000, 16'h0002, 16'h0004};
    seq_in = '{16'hA000, 16'hA002, 16'hA004};

    reset = 1'b1;
    pc_in = 16'h0; stall = 0; flush = 0; imem_ready = 0; imem_rdata = 16'h0;
    repeat (3) stepClock();
    checkOutput("reset_valid", {31'h0, if_id_valid}, 32'h0);
    checkOutput("reset_instr", {16'h0, if_id_instr}, 32'h0);
    reset = 1'b0;

    $display("[TB] zero-wait sequential fetch");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(seq_pc[i], 0, 0, 1, seq_in[i]);
      checkOutput("seq_busy", {31'h0, fetch_busy}, 32'h0);
      checkOutput("seq_addr", {16'h0, imem_addr}, {16'h0, seq_pc[i]});
      stepClock();
      checkIfId("seq", seq_in[i], seq_pc[i], seq_pc[i] + 16'd2);
    end

    $display("[TB] two wait states");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(16'h0010, 0, 0, 0, 16'hBAAD);
      checkOutput("wait_addr", {16'h0, imem_addr}, 32'h0010);
      checkOutput("wait_busy", {31'h0, fetch_busy}, 32'h1);
      stepClock();
      checkOutput("wait_valid", {31'h0, if_id_valid}, 32'h0);
    end
    applyStimulus(16'h0010, 0, 0, 1, 16'hB010);
    checkOutput("wait_done_busy", {31'h0, fetch_busy}, 32'h0);
    stepClock();
    checkIfId("wait", 16'hB010, 16'h0010, 16'h0012);

    $display("[TB] stall on ready cycle");
    applyStimulus(16'h0012, 1, 0, 1, 16'hC012);
    checkOutput("stall_busy", {31'h0, fetch_busy}, 32'h1);
    stepClock();
    checkIfId("stall_keep0", 16'hB010, 16'h0010, 16'h0012);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(16'h0012, 1, 0, 1, 16'hFFFF);
      checkOutput("hold_req", {31'h0, imem_req}, 32'h0);
      checkOutput("hold_busy", {31'h0, fetch_busy}, 32'h1);
      stepClock();
      checkIfId("stall_keep", 16'hB010, 16'h0010, 16'h0012);
    end
    applyStimulus(16'h0012, 0, 0, 0, 16'hFFFF);
    checkOutput("hold_release_req", {31'h0, imem_req}, 32'h0);
    stepClock();
    checkIfId("skid", 16'hC012, 16'h0012, 16'h0014);

    $display("[TB] flush during wait, then branch target");
    applyStimulus(16'h0014, 0, 0, 1, 16'hD014);
    stepClock();
    checkIfId("pre_flush", 16'hD014, 16'h0014, 16'h0016);
    applyStimulus(16'h0020, 0, 1, 0, 16'h0000);
    checkOutput("flush_addr", {16'h0, imem_addr}, 32'h0020);
    stepClock();
    checkOutput("flush_valid", {31'h0, if_id_valid}, 32'h0);
    applyStimulus(16'h0100, 0, 1, 0, 16'h0000);
    checkOutput("drain_addr", {16'h0, imem_addr}, 32'h0020);
    checkOutput("drain_busy", {31'h0, fetch_busy}, 32'h0);
    checkOutput("drain_req", {31'h0, imem_req}, 32'h1);
    stepClock();
    applyStimulus(16'h0100, 0, 0, 1, 16'hDEAD);
    checkOutput("drain_addr2", {16'h0, imem_addr}, 32'h0020);
    stepClock();
    checkOutput("drain_discard", {31'h0, if_id_valid}, 32'h0);
    applyStimulus(16'h0100, 0, 0, 1, 16'hE100);
    checkOutput("target_addr", {16'h0, imem_addr}, 32'h0100);
    stepClock();
    checkIfId("target", 16'hE100, 16'h0100, 16'h0102);

    $display("[TB] address wrap");
    applyStimulus(16'hFFFE, 0, 0, 1, 16'hF0FE);
    checkOutput("wrap_pc_plus2", {16'h0, pc_plus2}, 32'h0000);
    stepClock();
    checkIfId("wrap", 16'hF0FE, 16'hFFFE, 16'h0000);

    $display("[TB] flush while holding, flush with ready");
    applyStimulus(16'h0200, 1, 0, 1, 16'h5200);
    stepClock();
    applyStimulus(16'h0200, 1, 1, 0, 16'h0000);
    stepClock();
    checkOutput("hold_flush_valid", {31'h0, if_id_valid}, 32'h0);
    applyStimulus(16'h0400, 0, 0, 1, 16'h5400);
    checkOutput("after_hold_flush_req", {31'h0, imem_req}, 32'h1);
    checkOutput("after_hold_flush_addr", {16'h0, imem_addr}, 32'h0400);
    stepClock();
    checkIfId("after_hold_flush", 16'h5400, 16'h0400, 16'h0402);
    applyStimulus(16'h0402, 0, 1, 1, 16'h6666);
    checkOutput("ready_flush_busy", {31'h0, fetch_busy}, 32'h0);
    stepClock();
    checkOutput("ready_flush_valid", {31'h0, if_id_valid}, 32'h0);
    applyStimulus(16'h0300, 0, 0, 1, 16'h7300);
    checkOutput("ready_flush_next_addr", {16'h0, imem_addr}, 32'h0300);
    stepClock();
    checkIfId("pre_reset", 16'h7300, 16'h0300, 16'h0302);

    $display("[TB] reset mid-stream");
    applyStimulus(16'h0302, 0, 0, 1, 16'h7302);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", {31'h0, if_id_valid}, 32'h0);
    checkOutput("async_reset_instr", {16'h0, if_id_instr}, 32'h0);
    stepClock();
    stepClock();
    reset = 1'b0;
    #1;
    checkOutput("post_reset_req", {31'h0, imem_req}, 32'h1);
    checkOutput("post_reset_addr", {16'h0, imem_addr}, 32'h0302);
    stepClock();
    checkIfId("post_reset", 16'h7302, 16'h0302, 16'h0304);

    applyStimulus(16'h0304, 0, 0, 0, 16'h0000);
    repeat (3) stepClock();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
